// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package arb_pkg;
    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int HOLD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request scanning ptr, ptr+1, ... mod N_REQ.
import arb_pkg::*;

module rr_pick (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);
    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the closest-to-ptr hit wins last.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) pick = idx;
        end
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 8:1 data select with bounded bursts.
// Optional RR_ARB_LOCK_EN adds a lock input that suppresses the burst limit.
import arb_pkg::*;

module rr_mux_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] din,
    input  logic                    out_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic                    lock,
`endif
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        sel,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [SEL_W-1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [SEL_W-1:0]        pick;
    logic                    any;
    logic                    xfer;
    logic                    lock_act;
    logic [N_REQ-1:0][DATA_W-1:0] lanes;

    assign lanes = din;

`ifdef RR_ARB_LOCK_EN
    assign lock_act = lock;
`else
    assign lock_act = 1'b0;
`endif

    rr_pick u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        out_valid = 1'b0;
        out_data  = '0;
        ack       = '0;
        xfer      = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    sel_d   = pick;
                    grant_d = N_REQ'(1) << pick;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                out_valid = req[sel_q];
                if (out_valid) out_data = lanes[sel_q];
                xfer = out_valid & out_ready;
                if (xfer) begin
                    ack[sel_q] = 1'b1;
                    // Saturation only matters while lock holds off the release.
                    hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
                end
                if (!out_valid || (xfer && hold_q == HOLD_LAST && !lock_act)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + 1'b1;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (DATA_W=1, MAX_HOLD=4).
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = '0;
    logic [7:0] din = '0;
    logic       out_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
    logic       lock = 1'b0;
`endif
    logic       out_valid;
    logic [0:0] out_data;
    logic [2:0] sel;
    logic [7:0] grant;
    logic [7:0] ack;

    int total = 0;
    int bad   = 0;
    int lane;
    logic [7:0] dinv;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.DATA_W(1), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] g, input logic [2:0] s,
                       input logic v, input logic [7:0] a);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        if (g != 8'h00) chk({tag, "_sel"}, 32'(sel), 32'(s));
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_ack"}, 32'(ack), 32'(a));
    endtask

    initial begin
        // Reset held, then idle with no requests
        #1;
        cyc("rst", 8'h00, 3'd0, 1'b0, 8'h00);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cyc("t1_idle", 8'h00, 3'd0, 1'b0, 8'h00);
            chk("t1_sel", 32'(sel), 32'd0);
        end

        // Single requester on lane 3: 4-transfer burst, one idle, re-grant
        req = 8'h08; din = 8'h08; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc("t2_burst", 8'h08, 3'd3, 1'b1, 8'h08);
            chk("t2_data", 32'(out_data), 32'd1);
        end
        @(negedge clk);
        cyc("t2_idle", 8'h00, 3'd0, 1'b0, 8'h00);
        chk("t2_sel_kept", 32'(sel), 32'd3);
        @(negedge clk);
        cyc("t2_regrant", 8'h08, 3'd3, 1'b1, 8'h08);
        req = 8'h00;
        #1;
        cyc("t2_withdraw", 8'h08, 3'd3, 1'b0, 8'h00);
        @(negedge clk);
        cyc("t2_idle2", 8'h00, 3'd0, 1'b0, 8'h00);

        // Reset while idle brings ptr back to 0
        rst_n = 1'b0;
        #1;
        cyc("rst2", 8'h00, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Full rotation 0..7 then wrap to 0, one idle cycle between grants
        req = 8'hFF; din = 8'hA5; dinv = 8'hA5;
        for (int g = 0; g < 9; g++) begin
            lane = g % 8;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                cyc("t3_rot", 8'(1) << lane, 3'(lane), 1'b1, 8'(1) << lane);
                chk("t3_data", 32'(out_data), 32'(dinv[lane]));
            end
            @(negedge clk);
            cyc("t3_gap", 8'h00, 3'd0, 1'b0, 8'h00);
        end
        req = 8'h00;

        // Backpressure on lane 5 (ptr is 1)
        req = 8'h20; din = 8'h20; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc("t4_stall", 8'h20, 3'd5, 1'b1, 8'h00);
            chk("t4_data", 32'(out_data), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_ack_same", 32'(ack), 32'h20);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc("t4_burst", 8'h20, 3'd5, 1'b1, 8'h20);
        end
        @(negedge clk);
        cyc("t4_idle", 8'h00, 3'd0, 1'b0, 8'h00);
        req = 8'h00;

        // Withdrawal on lane 2 after one transfer; next grant from ptr=3
        req = 8'h04; din = 8'h00;
        @(negedge clk);
        cyc("t5_first", 8'h04, 3'd2, 1'b1, 8'h04);
        @(negedge clk);
        req = 8'h01;
        #1;
        cyc("t5_drop", 8'h04, 3'd2, 1'b0, 8'h00);
        @(negedge clk);
        cyc("t5_idle", 8'h00, 3'd0, 1'b0, 8'h00);
        req = 8'h05;
        @(negedge clk);
        cyc("t5_next", 8'h01, 3'd0, 1'b1, 8'h01);
        req = 8'h00;
        @(negedge clk);
        cyc("t5_idle2", 8'h00, 3'd0, 1'b0, 8'h00);

        // Reset mid-burst on lane 6 at hold_cnt=2
        req = 8'h40; din = 8'h40;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cyc("t6_burst", 8'h40, 3'd6, 1'b1, 8'h40);
        end
        rst_n = 1'b0;
        #1;
        cyc("t6_rst", 8'h00, 3'd0, 1'b0, 8'h00);
        chk("t6_rst_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h41;
        @(negedge clk);
        cyc("t6_ptr0", 8'h01, 3'd0, 1'b1, 8'h01);
        req = 8'h40;
`ifdef RR_ARB_LOCK_EN
        lock = 1'b1;
`endif
        @(negedge clk);
        cyc("t6_idle", 8'h00, 3'd0, 1'b0, 8'h00);
`ifdef RR_ARB_LOCK_EN
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            cyc("t6_lock", 8'h40, 3'd6, 1'b1, 8'h40);
        end
        lock = 1'b0;
        @(negedge clk);
        cyc("t6_unlock_idle", 8'h00, 3'd0, 1'b0, 8'h00);
`else
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc("t6_limit", 8'h40, 3'd6, 1'b1, 8'h40);
        end
        @(negedge clk);
        cyc("t6_limit_idle", 8'h00, 3'd0, 1'b0, 8'h00);
`endif
        req = 8'h00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
